bmd_64_wdma_tlp_seq: RTL
========================

// Module: bmd_64_wdma_tlp_seq
// PURPOSE
//  Write-DMA TLP sequencer, directly downstream of the write-DMA frame FSM. On each frame start it
//  splits one CC frame (mwr_count_i TLPs of mwr_len_i DWORDs) into memory-write header requests
//  for the 64-bit TX engine. It steps the host address and returns a single-cycle done when the
//  last header has been accepted.
// PARAMETERS
//  ADDR_W      40  host byte-address width
//  GAP_CYCLES  0   idle cycles inserted between consecutive requests (0..255)
// PORTS
//  clk           in   1       single clock; every register is clocked on its rising edge
//  rst           in   1       synchronous, active-high reset
//  init_rst_i    in   1       soft abort from the control registers; synchronous, same effect as rst
//  wdma_start_i  in   1       level from the frame FSM; held high until done is seen
//  wdma_addr_i   in   ADDR_W  frame base byte address; sampled when a start is accepted
//  mwr_len_i     in   10      DWORDs per TLP; 0 encodes 1024
//  mwr_count_i   in   16      TLPs per frame
//  wdma_done_o   out  1       one-cycle pulse: frame fully issued
//  mwr_req_o     out  1       header request to the TX engine
//  mwr_addr_o    out  ADDR_W  byte address of the current TLP
//  mwr_len_o     out  10      length field of the current TLP
//  mwr_fmt64_o   out  1       1 = 4DW header, used when mwr_addr_o[ADDR_W-1:32] != 0
//  mwr_ack_i     in   1       TX engine accepted the header presented this cycle
//  seq_busy_o    out  1       high in every state except IDLE
//  tlp_cnt_o     out  16      TLPs acknowledged in the current frame
//  dma_cycles_o  out  32      frame duration in cycles (optional feature only)
// BEHAVIOUR
//  Reset (rst or init_rst_i): state IDLE; every output is 0.
//  States:
//   IDLE   if start=1: latch addr, len and count; clear tlp_cnt.
//          count=0 -> DONE, otherwise -> ISSUE.
//   ISSUE  mwr_req_o=1; addr, len and fmt64 stay stable while req=1.
//          On ack: addr += bytes; tlp_cnt += 1.
//          If this was the last TLP -> DONE; else GAP_CYCLES=0 ? stay in ISSUE : go to GAP.
//   GAP    mwr_req_o=0; count down GAP_CYCLES, then -> ISSUE.
//   DONE   wdma_done_o=1 for exactly one cycle -> HOLD.
//   HOLD   wait for start=0 -> IDLE, so a start level still high after done never retriggers.
//  Latency:
//   - start high in cycle N (from IDLE) -> first mwr_req_o in cycle N+1.
//   - ack of the last TLP in cycle M -> wdma_done_o in cycle M+1.
//   - count=0 -> done in cycle N+2, no request issued.
//  Back-to-back issue: with GAP_CYCLES=0 and ack held high, one TLP is accepted per cycle.
//  Byte step per TLP: len=0 -> 4096; otherwise 4*len. Address addition wraps modulo 2^ADDR_W.
//  fmt64 is computed from the address of the current TLP, so it can change mid-frame when the
//  address crosses 4 GiB.
//  mwr_len_i, mwr_count_i and wdma_addr_i changes after latching have no effect until the next start.
//  ack while mwr_req_o=0 is ignored.
//  start dropping mid-frame is ignored: the frame completes and done still pulses.
//  init_rst_i mid-frame: req drops the next cycle and no done pulse is produced.
// CONFIGURATION
//  WDMA_SEQ_PERF_EN defined:
//   - 32-bit counter clears on start accept, increments every cycle in ISSUE and GAP, saturates.
//   - Its value is copied to dma_cycles_o in the DONE cycle and held until the next done or reset.
//  Not defined: dma_cycles_o is tied to 0 and no counter logic is built.
// STRUCTURE
//  Shared package bmd_wdma_pkg holds:
//   - state encoding, one-hot 5 bits: IDLE, ISSUE, GAP, DONE, HOLD;
//   - constant MWR_MAX_BYTES = 4096;
//   - function mwr_bytes(len) returning the byte step.
//  No sub-module; gap timer and counters are inline.
// TESTING
//  1. len=32, count=4, addr=0x0000_1000, ack always 1, GAP=0 -> 4 requests at
//     0x1000, 0x1080, 0x1100, 0x1180; done 1 cycle after the 4th ack; tlp_cnt=4.
//  2. len=0, count=2, addr=0xFF_FFFF_F000 -> addresses 0xFF_FFFF_F000, then 0x00_0000_0000;
//     fmt64 = 1, then 0.
//  3. addr=0x0_FFFF_FF80, len=32, count=2 -> fmt64 0, then 1 (second TLP at 0x1_0000_0000).
//  4. count=0 -> done 2 cycles after start, mwr_req_o never asserted; start kept high
//     5 more cycles -> no second done.
//  5. GAP_CYCLES=3, ack delayed 2 cycles per request -> addr and len stable while req=1;
//     exactly 3 req-low cycles between TLPs.
//  6. init_rst_i after 2 of 8 acks -> req=0 next cycle, no done; restart completes 8 TLPs from the
//     new base; with WDMA_SEQ_PERF_EN, dma_cycles_o=8 for 8 TLPs with ack=1, GAP=0.

Source files
------------

// File: rtl/bmd_wdma_pkg.sv
// Shared types for the write-DMA TLP sequencer: one-hot state encoding,
// maximum TLP payload and the per-TLP byte step helper.
package bmd_wdma_pkg;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_ISSUE = 5'b00010,
      ST_GAP   = 5'b00100,
      ST_DONE  = 5'b01000,
      ST_HOLD  = 5'b10000
   } seq_state_e;

   localparam int unsigned MWR_MAX_BYTES = 4096;

   // A length field of 0 means the maximum of 1024 DWORDs.
   function automatic logic [12:0] mwr_bytes(input logic [9:0] len);
      return (len == 10'd0) ? 13'(MWR_MAX_BYTES) : {1'b0, len, 2'b00};
   endfunction

endpackage

// File: rtl/bmd_64_wdma_tlp_seq.sv
// Write-DMA TLP sequencer: splits one frame into memory-write header requests.
// Optional frame cycle counter enabled by defining WDMA_SEQ_PERF_EN.
module bmd_64_wdma_tlp_seq
   import bmd_wdma_pkg::*;
#(
   parameter int ADDR_W     = 40,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_rst_i,
   input  logic              wdma_start_i,
   input  logic [ADDR_W-1:0] wdma_addr_i,
   input  logic [9:0]        mwr_len_i,
   input  logic [15:0]       mwr_count_i,
   output logic              wdma_done_o,
   output logic              mwr_req_o,
   output logic [ADDR_W-1:0] mwr_addr_o,
   output logic [9:0]        mwr_len_o,
   output logic              mwr_fmt64_o,
   input  logic              mwr_ack_i,
   output logic              seq_busy_o,
   output logic [15:0]       tlp_cnt_o,
   output logic [31:0]       dma_cycles_o
);

   localparam bit         GAP_EN   = (GAP_CYCLES != 0);
   localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   seq_state_e        state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [9:0]        len_q;
   logic [15:0]       count_q;
   logic [15:0]       tlp_cnt_q;
   logic [7:0]        gap_q;
   logic              zero_q;
   logic              soft_rst;
   logic              start_acc;
   logic              ack_acc;
   logic              last_tlp;

   assign soft_rst  = rst | init_rst_i;
   assign start_acc = (state == ST_IDLE) & wdma_start_i;
   assign ack_acc   = (state == ST_ISSUE) & mwr_ack_i;
   assign last_tlp  = (tlp_cnt_q == (count_q - 16'd1));

   always_ff @(posedge clk) begin
      if (soft_rst) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (wdma_start_i)
                      state_nxt = (mwr_count_i == 16'd0) ? ST_DONE : ST_ISSUE;
         ST_ISSUE: if (mwr_ack_i) begin
                      if (last_tlp)    state_nxt = ST_DONE;
                      else if (GAP_EN) state_nxt = ST_GAP;
                   end
         ST_GAP:   if (gap_q == 8'd0) state_nxt = ST_ISSUE;
         // An empty frame spends one extra cycle here so done lands two cycles after start.
         ST_DONE:  if (!zero_q) state_nxt = ST_HOLD;
         ST_HOLD:  if (!wdma_start_i) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (soft_rst) begin
         addr_q    <= '0;
         len_q     <= '0;
         count_q   <= '0;
         tlp_cnt_q <= '0;
         gap_q     <= '0;
         zero_q    <= 1'b0;
      end else begin
         if (start_acc) begin
            addr_q    <= wdma_addr_i;
            len_q     <= mwr_len_i;
            count_q   <= mwr_count_i;
            tlp_cnt_q <= '0;
            zero_q    <= (mwr_count_i == 16'd0);
         end
         if (ack_acc) begin
            addr_q    <= addr_q + ADDR_W'(mwr_bytes(len_q));
            tlp_cnt_q <= tlp_cnt_q + 16'd1;
            gap_q     <= GAP_LOAD;
         end
         if ((state == ST_GAP) && (gap_q != 8'd0)) gap_q <= gap_q - 8'd1;
         if (state == ST_DONE) zero_q <= 1'b0;
      end
   end

   assign mwr_req_o   = (state == ST_ISSUE);
   assign wdma_done_o = (state == ST_DONE) & ~zero_q;
   assign seq_busy_o  = (state != ST_IDLE);
   assign mwr_addr_o  = addr_q;
   assign mwr_len_o   = len_q;
   assign mwr_fmt64_o = |addr_q[ADDR_W-1:32];
   assign tlp_cnt_o   = tlp_cnt_q;

`ifdef WDMA_SEQ_PERF_EN
   logic [31:0] perf_q;
   logic [31:0] dma_cycles_q;

   always_ff @(posedge clk) begin
      if (soft_rst) begin
         perf_q       <= '0;
         dma_cycles_q <= '0;
      end else begin
         if (start_acc)
            perf_q <= '0;
         else if (((state == ST_ISSUE) || (state == ST_GAP)) && (perf_q != '1))
            perf_q <= perf_q + 32'd1;
         if (wdma_done_o) dma_cycles_q <= perf_q;
      end
   end

   assign dma_cycles_o = dma_cycles_q;
`else
   assign dma_cycles_o = '0;
`endif

endmodule
